// File: rtl/wl_sfifo.sv
// wl_sfifo: single-clock FIFO with arbitrary depth, occupancy counter and threshold flags.
// Define WL_SFIFO_FWFT_EN for first-word-fall-through reads; by default rdata is registered.
module wl_sfifo #(
  parameter int DW    = 16,
  parameter int H     = 12,
  parameter int AF_TH = 10,
  parameter int AE_TH = 2,
  localparam int L    = $clog2(H),
  localparam int LW   = $clog2(H + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          wfull,
  output logic          rempty,
  output logic          awfull,
  output logic          arempty,
  output logic          overflow,
  output logic          underflow,
  output logic [LW-1:0] level
);

  localparam logic [L-1:0]  PTR_LAST = L'(H - 1);
  localparam logic [LW-1:0] DEPTH    = LW'(H);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_TH);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_TH);

  logic [DW-1:0] mem [H];
  logic [L-1:0]  wptr;
  logic [L-1:0]  rptr;
  logic          wa;
  logic          ra;
  logic [LW-1:0] level_next;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [L-1:0] ptr_inc(input logic [L-1:0] p);
    return (p == PTR_LAST) ? '0 : p + L'(1);
  endfunction

  // Gating uses the registered flags only; clr also suppresses both accepts.
  assign wa = we & ~wfull  & ~clr;
  assign ra = re & ~rempty & ~clr;

  always_comb begin
    level_next = level;
    case ({wa, ra})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      wfull     <= 1'b0;
      rempty    <= 1'b1;
      awfull    <= 1'b0;
      arempty   <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      wfull     <= 1'b0;
      rempty    <= 1'b1;
      awfull    <= 1'b0;
      arempty   <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wptr <= ptr_inc(wptr);
      if (ra) rptr <= ptr_inc(rptr);
      level     <= level_next;
      wfull     <= (level_next == DEPTH);
      rempty    <= (level_next == '0);
      awfull    <= (level_next >= AF_LVL);
      arempty   <= (level_next <= AE_LVL);
      overflow  <= we & wfull;
      underflow <= re & rempty;
    end
  end

  // Storage is deliberately left out of reset and clear.
  always_ff @(posedge clk) begin
    if (wa) mem[wptr] <= wdata;
  end

`ifdef WL_SFIFO_FWFT_EN
  assign rdata  = mem[rptr];
  assign rvalid = ~rempty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (clr) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ra;
      if (ra) rdata <= mem[rptr];
    end
  end
`endif

endmodule

// File: tb/tb_wl_sfifo.sv
// Self-checking bench for wl_sfifo: reference level/flag model plus a data scoreboard queue.
module tb_wl_sfifo;
  localparam int DW    = 16;
  localparam int H     = 12;
  localparam int AF_TH = 10;
  localparam int AE_TH = 2;
  localparam int LW    = $clog2(H + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          we;
  logic [DW-1:0] wdata;
  logic          re;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          wfull;
  logic          rempty;
  logic          awfull;
  logic          arempty;
  logic          overflow;
  logic          underflow;
  logic [LW-1:0] level;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] sb[$];
  int            m_level     = 0;
  logic [DW-1:0] last_rd     = '0;

  wl_sfifo #(.DW(DW), .H(H), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wdata(wdata), .re(re),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .awfull(awfull), .arempty(arempty), .overflow(overflow),
    .underflow(underflow), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock of stimulus; the model predicts and the scoreboard checks the result.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    logic          wa_e, ra_e, ov_e, un_e;
    logic [DW-1:0] exp_d;
    logic [5:0]    exp_flags;
    we = w; wdata = d; re = r; clr = c;
`ifdef WL_SFIFO_FWFT_EN
    if (m_level > 0) begin
      vectors++;
      if (rdata !== sb[0]) begin
        miscompares++;
        $display("FAIL fwft_head: rdata=%h expected %h", rdata, sb[0]);
      end
    end
`endif
    ov_e = !c && w && (m_level == H);
    un_e = !c && r && (m_level == 0);
    wa_e = !c && w && (m_level != H);
    ra_e = !c && r && (m_level != 0);
    exp_d = last_rd;
    if (c) begin
      sb.delete();
      m_level = 0;
      exp_d = '0;
    end else begin
      if (ra_e) begin
        exp_d = sb.pop_front();
        m_level--;
      end
      if (wa_e) begin
        sb.push_back(d);
        m_level++;
      end
    end
    last_rd = exp_d;
    @(posedge clk);
    #1;
    exp_flags = {m_level == H, m_level == 0, m_level >= AF_TH, m_level <= AE_TH, ov_e, un_e};
    vectors++;
    if (level !== LW'(m_level)) begin
      miscompares++;
      $display("FAIL level: got %0d expected %0d", level, m_level);
    end
    vectors++;
    if ({wfull, rempty, awfull, arempty, overflow, underflow} !== exp_flags) begin
      miscompares++;
      $display("FAIL flags{wfull,rempty,awfull,arempty,ovf,unf}: got %b expected %b",
               {wfull, rempty, awfull, arempty, overflow, underflow}, exp_flags);
    end
`ifdef WL_SFIFO_FWFT_EN
    vectors++;
    if (rvalid !== (m_level != 0)) begin
      miscompares++;
      $display("FAIL rvalid: got %b expected %b", rvalid, m_level != 0);
    end
`else
    vectors++;
    if (rvalid !== ra_e) begin
      miscompares++;
      $display("FAIL rvalid: got %b expected %b", rvalid, ra_e);
    end
    vectors++;
    if (rdata !== exp_d) begin
      miscompares++;
      $display("FAIL rdata: got %h expected %h", rdata, exp_d);
    end
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < H + 1 && m_level > 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if ({level, wfull, rempty, awfull, arempty, overflow, underflow, rvalid} !==
        {LW'(0), 7'b0101000}) begin
      miscompares++;
      $display("FAIL reset_state: got lvl=%0d flags=%b%b%b%b%b%b rvalid=%b", level,
               wfull, rempty, awfull, arempty, overflow, underflow, rvalid);
    end
`ifndef WL_SFIFO_FWFT_EN
    vectors++;
    if (rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h expected 0000", rdata);
    end
`endif
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (level !== LW'(5)) begin
      miscompares++;
      $display("FAIL pre_reset_level: got %0d expected 5", level);
    end
    we = 1'b0; re = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({level, rempty, arempty, wfull, rvalid} !== {LW'(0), 4'b1100}) begin
      miscompares++;
      $display("FAIL async_reset: got lvl=%0d rempty=%b arempty=%b wfull=%b rvalid=%b expected 0 1 1 0 0",
               level, rempty, arempty, wfull, rvalid);
    end
    sb.delete(); m_level = 0; last_rd = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= H; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == AF_TH - 1 || i == AF_TH) begin
        vectors++;
        if (awfull !== (i == AF_TH)) begin
          miscompares++;
          $display("FAIL awfull_edge: level %0d awfull=%b expected %b", i, awfull, i == AF_TH);
        end
      end
      if (i == H - 1 || i == H) begin
        vectors++;
        if (wfull !== (i == H)) begin
          miscompares++;
          $display("FAIL wfull_edge: level %0d wfull=%b expected %b", i, wfull, i == H);
        end
      end
    end
    cyc(1'b1, DW'(16'h00EE), 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || level !== LW'(H)) begin
      miscompares++;
      $display("FAIL overflow: got ovf=%b lvl=%0d expected 1 12", overflow, level);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_pulse: got %b expected 0", overflow);
    end
    for (int i = 1; i <= H; i++) begin
`ifdef WL_SFIFO_FWFT_EN
      vectors++;
      if (rdata !== DW'(i)) begin
        miscompares++;
        $display("FAIL drain_order: got %h expected %h", rdata, DW'(i));
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
`else
      cyc(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (rdata !== DW'(i)) begin
        miscompares++;
        $display("FAIL drain_order: got %h expected %h", rdata, DW'(i));
      end
`endif
    end
    vectors++;
    if (rempty !== 1'b1) begin
      miscompares++;
      $display("FAIL drained_empty: got %b expected 1", rempty);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow: got %b expected 1", underflow);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_pulse: got %b expected 0", underflow);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, DW'(16'h0300 + i), 1'b1, 1'b0);
      vectors++;
      if (level !== LW'(3)) begin
        miscompares++;
        $display("FAIL wrap_level: cycle %0d got %0d expected 3", i, level);
      end
    end
    drain();
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < H; i++) cyc(1'b1, DW'(16'h0400 + i), 1'b0, 1'b0);
    cyc(1'b1, DW'(16'h04FF), 1'b1, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || level !== LW'(H - 1)) begin
      miscompares++;
      $display("FAIL full_simul: got ovf=%b lvl=%0d expected 1 11", overflow, level);
    end
    drain();
  endtask

  task automatic test_clr();
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(16'h0500 + i), 1'b0, 1'b0);
    cyc(1'b1, DW'(16'hDEAD), 1'b0, 1'b1);
    vectors++;
    if (level !== LW'(0) || rempty !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_priority: got lvl=%0d rempty=%b expected 0 1", level, rempty);
    end
    cyc(1'b1, DW'(16'hABCD), 1'b0, 1'b0);
`ifdef WL_SFIFO_FWFT_EN
    vectors++;
    if (rdata !== DW'(16'hABCD)) begin
      miscompares++;
      $display("FAIL clr_new_word: got %h expected abcd", rdata);
    end
`endif
    cyc(1'b0, '0, 1'b1, 1'b0);
`ifndef WL_SFIFO_FWFT_EN
    vectors++;
    if (rdata !== DW'(16'hABCD)) begin
      miscompares++;
      $display("FAIL clr_new_word: got %h expected abcd", rdata);
    end
`endif
  endtask

  task automatic test_latency();
    cyc(1'b1, DW'(16'h1234), 1'b0, 1'b0);
`ifdef WL_SFIFO_FWFT_EN
    vectors++;
    if (rvalid !== 1'b1 || rdata !== DW'(16'h1234)) begin
      miscompares++;
      $display("FAIL fwft_latency: got rvalid=%b rdata=%h expected 1 1234", rvalid, rdata);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
`else
    vectors++;
    if (rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL std_latency_pre: got rvalid=%b expected 0", rvalid);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (rvalid !== 1'b1 || rdata !== DW'(16'h1234)) begin
      miscompares++;
      $display("FAIL std_latency: got rvalid=%b rdata=%h expected 1 1234", rvalid, rdata);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (rvalid !== 1'b0 || rdata !== DW'(16'h1234)) begin
      miscompares++;
      $display("FAIL std_hold: got rvalid=%b rdata=%h expected 0 1234", rvalid, rdata);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_clr();
    test_latency();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
